spi_matrix_loader: RTL
======================

# spi_matrix_loader

SPI-slave matrix loader for the systolic array front end. It receives SPI bytes over oversampled pins, decodes a load command, and assembles multi-byte little-endian elements. It then writes each element into one of several on-chip operand matrices. The SPI pins are synchronised into the single system clock domain, so no logic runs on `sclk`. It generalises the single-matrix, 16-bit, 4×4 load path to parametrised element width, matrix size and matrix count.

## Interface
- `DATA_W`, 16: element width in bits (8..32); `BYTES = ceil(DATA_W/8)`.
- `N`, 4: matrix dimension; `N*N` elements per matrix; `ADDR_W = clog2(N*N)`.
- `NUM_MAT`, 2: number of target matrices (1..8); `SEL_W = max(1, clog2(NUM_MAT))`.
- `CMD_BASE`, 8'h10: command byte `CMD_BASE+m` loads matrix `m`.

Ports:
- `clk` input 1: system clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sclk` input 1: SPI clock (asynchronous, mode 0); sampled on the rising edge.
- `mosi` input 1: SPI data, MSB first.
- `cs_n` input 1: SPI chip select, active low.
- `wr_en` output 1: one-cycle element write strobe.
- `wr_sel` output SEL_W: target matrix index.
- `wr_addr` output ADDR_W: row-major element index.
- `wr_data` output DATA_W: assembled element.
- `done` output 1: one-cycle pulse after the last element (and checksum) of a matrix.
- `err` output 1: one-cycle pulse on a bad command, or on a checksum mismatch.
- `busy` output 1: high while in `LOAD` or `CHK`.

## Operation
- **Synchronisers.** `sclk`, `mosi` and `cs_n` each pass through a 2-flop synchroniser. A third flop on `sclk` provides rising-edge detection: `rise = s2 & ~s3`.
- **Byte assembly.** On `rise` with synced `cs_n` low, shift the synced `mosi` into `shift[7:0]` and increment a 3-bit `bit_cnt`. On the 8th bit, the completed byte and `byte_vld` register on the next edge.
- **Chip select.** While synced `cs_n` is high, `bit_cnt` is held at 0 and a partial byte is discarded. The state machine state is kept, so per-byte CS toggling is legal.
- **State `IDLE`.** On `byte_vld`:
  - If the byte is in `CMD_BASE .. CMD_BASE+NUM_MAT-1`: latch `m = byte-CMD_BASE`, clear `elem_idx`/`byte_idx`, go to `LOAD`.
  - Otherwise pulse `err` and stay in `IDLE`.
- **State `LOAD`.** Each `byte_vld` writes `acc[8*byte_idx +: 8]`.
  - When `byte_idx == BYTES-1`: issue a write (`wr_data = acc` truncated to `DATA_W`, `wr_addr = elem_idx`, `wr_sel = m`), clear `byte_idx`, increment `elem_idx`.
  - When `elem_idx == N*N-1`: go to `CHK` if enabled, else pulse `done` and return to `IDLE`.
- **Accumulator.** `acc` clears after each element, so bits above `DATA_W` are dropped.
- **No abort by command.** A command-valued byte in `LOAD` is treated as data.
- **No wrap-around.** `elem_idx` never wraps; the transition out of `LOAD` occurs at the last element.
- **Reset mid-load.** All state returns to `IDLE`, counters clear, and no `wr_en` is issued.

## Timing
- **Reset values.** `wr_en=0`, `wr_sel=0`, `wr_addr=0`, `wr_data=0`, `done=0`, `err=0`, `busy=0`.
- **SCLK limits.** `sclk` high and low phases must each be ≥ 2 `clk` periods. `mosi` must be stable for ≥ 3 `clk` around the `sclk` rise.
- **Latency.** Let edge E be the first `clk` edge at which `sclk` samples high for bit 8 of a byte.
  - `byte_vld` is high after edge E+3.
  - `wr_en`, `done` or `err` are high after edge E+4, for exactly one cycle.
- **Output hold.** `wr_addr`, `wr_data` and `wr_sel` hold their values until the next write.
- **`busy` timing.** `busy` rises with entry to `LOAD` and falls in the same cycle that `done` or `err` is pulsed.

## Configuration
- **`SPI_LOADER_CHECKSUM_EN` defined.** After the last element the FSM enters `CHK`.
  - The next byte is compared with the running XOR of all data bytes of that load.
  - On a match, pulse `done`; on a mismatch, pulse `err` and not `done`. Both cases return to `IDLE`.
  - Writes already issued are not undone.
- **Not defined.** There is no `CHK` state and no XOR register; `done` pulses after the last write.

## Test plan
- **Default single element.** Defaults; send 0x10, 0x01, 0x00 with CS toggled per byte → `wr_en` with `wr_sel=0`, `wr_addr=0`, `wr_data=16'h0001`, arriving 4 clk after the detected edge.
- **Full second matrix.** Send 0x11, then 32 bytes encoding values 0..15 → 16 writes, `wr_sel=1`, `wr_addr` 0..15 with matching data. `done` pulses once after addr 15; `busy` is low afterwards.
- **Bad command.** Send 0x3F in `IDLE` → `err` pulses, no writes, state stays `IDLE`. A following 0x10 load then succeeds.
- **Partial byte abort.** Raise `cs_n` after 5 bits, then send a full 0x10 → the partial bits are ignored, the FSM enters `LOAD`, and the first element assembles correctly.
- **Wider element, reset mid-load.** `DATA_W=24`, `N=2`: send 0x10 then bytes 0x56, 0x34, 0x12 → `wr_data=24'h123456`. Assert `rst` after element 1 → all outputs return to 0, and the next bytes trigger no writes until a new command arrives.
- **Checksum (with `SPI_LOADER_CHECKSUM_EN`).** Correct XOR byte → `done`. Corrupted XOR byte → `err` and no `done`.

Source files
------------

// File: rtl/spi_matrix_loader.sv
// SPI-slave matrix loader: oversampled SPI byte receiver feeding a command/element FSM.
// Optional trailing XOR checksum byte per matrix when SPI_LOADER_CHECKSUM_EN is defined.
module spi_matrix_loader #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned N        = 4,
  parameter int unsigned NUM_MAT  = 2,
  parameter logic [7:0]  CMD_BASE = 8'h10,
  localparam int unsigned BYTES   = (DATA_W + 7) / 8,
  localparam int unsigned ADDR_W  = $clog2(N * N),
  localparam int unsigned SEL_W   = (NUM_MAT > 1) ? $clog2(NUM_MAT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs_n,
  output logic              wr_en,
  output logic [SEL_W-1:0]  wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              done,
  output logic              err,
  output logic              busy
);

  localparam int unsigned BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

`ifdef SPI_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHK} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD} state_t;
`endif

  logic [2:0] sclk_sync_q;
  logic [1:0] mosi_sync_q;
  logic [1:0] csn_sync_q;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       full_q;
  logic [7:0] byte_q;
  logic       byte_vld_q;
  logic       rise;

  assign rise = sclk_sync_q[1] & ~sclk_sync_q[2];

  // full_q delays the byte by one stage so byte_vld lands three clocks after the sampled edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      csn_sync_q  <= '1;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      full_q      <= 1'b0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], sclk};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      csn_sync_q  <= {csn_sync_q[0], cs_n};
      full_q      <= 1'b0;
      if (csn_sync_q[1]) begin
        bit_cnt_q <= '0;
      end else if (rise) begin
        shift_q   <= {shift_q[6:0], mosi_sync_q[1]};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        full_q    <= (bit_cnt_q == 3'd7);
      end
      byte_vld_q <= full_q;
      if (full_q) byte_q <= shift_q;
    end
  end

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [ADDR_W-1:0]   elem_q, elem_d;
  logic [BIDX_W-1:0]   bidx_q, bidx_d;
  logic [8*BYTES-1:0]  acc_q, acc_d, acc_nxt;
  logic                wr_en_q, wr_en_d;
  logic [SEL_W-1:0]    wr_sel_q, wr_sel_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [7:0]          cmd_off;
  logic                is_cmd;
`ifdef SPI_LOADER_CHECKSUM_EN
  logic [7:0]          xor_q, xor_d;
`endif

  assign cmd_off = byte_q - CMD_BASE;
  assign is_cmd  = (byte_q >= CMD_BASE) && (32'(cmd_off) < NUM_MAT);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    elem_d    = elem_q;
    bidx_d    = bidx_q;
    acc_d     = acc_q;
    acc_nxt   = acc_q;
    wr_en_d   = 1'b0;
    wr_sel_d  = wr_sel_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef SPI_LOADER_CHECKSUM_EN
    xor_d     = xor_q;
`endif
    case (state_q)
      IDLE: begin
        if (byte_vld_q) begin
          if (is_cmd) begin
            sel_d   = cmd_off[SEL_W-1:0];
            elem_d  = '0;
            bidx_d  = '0;
            acc_d   = '0;
            state_d = LOAD;
`ifdef SPI_LOADER_CHECKSUM_EN
            xor_d   = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (byte_vld_q) begin
          acc_nxt[8*int'(bidx_q) +: 8] = byte_q;
`ifdef SPI_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ byte_q;
`endif
          if (bidx_q == BIDX_W'(BYTES - 1)) begin
            wr_en_d   = 1'b1;
            wr_sel_d  = sel_q;
            wr_addr_d = elem_q;
            wr_data_d = acc_nxt[DATA_W-1:0];
            acc_d     = '0;
            bidx_d    = '0;
            if (elem_q == ADDR_W'(N * N - 1)) begin
`ifdef SPI_LOADER_CHECKSUM_EN
              state_d = CHK;
`else
              done_d  = 1'b1;
              state_d = IDLE;
`endif
            end else begin
              elem_d = elem_q + ADDR_W'(1);
            end
          end else begin
            acc_d  = acc_nxt;
            bidx_d = bidx_q + BIDX_W'(1);
          end
        end
      end
`ifdef SPI_LOADER_CHECKSUM_EN
      CHK: begin
        if (byte_vld_q) begin
          if (byte_q == xor_q) done_d = 1'b1;
          else                 err_d  = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      elem_q    <= '0;
      bidx_q    <= '0;
      acc_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef SPI_LOADER_CHECKSUM_EN
      xor_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      elem_q    <= elem_d;
      bidx_q    <= bidx_d;
      acc_q     <= acc_d;
      wr_en_q   <= wr_en_d;
      wr_sel_q  <= wr_sel_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef SPI_LOADER_CHECKSUM_EN
      xor_q     <= xor_d;
`endif
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_sel  = wr_sel_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = (state_q != IDLE);

endmodule
